// File: rtl/simd_fetch_unit.sv
// Instruction fetch stage: walks instruction memory from a start PC into a small
// show-ahead prefetch FIFO, stops at RET, drains, then pulses done.
module simd_fetch_unit #(
    parameter int          ADDR_W     = 8,
    parameter int          DEPTH      = 2,
    parameter logic [10:0] RET_OPCODE = 11'b11010110010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  count_q, count_d, outst_q, outst_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]       word_q [DEPTH];
    logic [31:0]       word_d [DEPTH];
    logic [ADDR_W-1:0] wpc_q [DEPTH];
    logic [ADDR_W-1:0] wpc_d [DEPTH];
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic              done_q, done_d;

    logic              rsp_take, push, pop, ret_push, req, gnt_ok, fifo_nonempty;
    logic [CNT_W:0]    inflight;

    always_comb begin
        inflight      = {1'b0, count_q} + {1'b0, outst_q};
        fifo_nonempty = (count_q != '0);
        // Responses with nothing outstanding (e.g. in flight across a reset) are ignored.
        rsp_take      = imem_rvalid && (outst_q != '0);
        push          = rsp_take && (state_q == FETCH);
        ret_push      = push && (imem_rdata[31:21] == RET_OPCODE);
        req           = (state_q == FETCH) && (inflight < (CNT_W + 1)'(DEPTH)) && !ret_push;
        gnt_ok        = req && imem_gnt;
        pop           = fifo_nonempty && instr_ready;

        pc_d         = gnt_ok ? pc_q + ADDR_W'(1) : pc_q;
        rsp_pc_d     = rsp_take ? rsp_pc_q + ADDR_W'(1) : rsp_pc_q;
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        word_d       = word_q;
        wpc_d        = wpc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if (push) begin
            word_d[wr_ptr_q] = imem_rdata;
            wpc_d[wr_ptr_q]  = rsp_pc_q;
        end
        if (pop) begin
            hold_instr_d = word_q[rd_ptr_q];
            hold_pc_d    = wpc_q[rd_ptr_q];
        end

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        outst_d = outst_q;
        if (gnt_ok && !rsp_take)      outst_d = outst_q + CNT_W'(1);
        else if (rsp_take && !gnt_ok) outst_d = outst_q - CNT_W'(1);

        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q marks the first IDLE cycle, where a new start is not yet taken.
                if (start && !done_q) begin
                    state_d  = FETCH;
                    pc_d     = start_pc;
                    rsp_pc_d = start_pc;
                end
            end
            FETCH: if (ret_push) state_d = DRAIN;
            DRAIN: begin
                if (!fifo_nonempty && (outst_q == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            rsp_pc_q     <= '0;
            count_q      <= '0;
            outst_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            done_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                wpc_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rsp_pc_q     <= rsp_pc_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            done_q       <= done_d;
            word_q       <= word_d;
            wpc_q        <= wpc_d;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign instr_valid = fifo_nonempty;
    assign instruction = fifo_nonempty ? word_q[rd_ptr_q] : hold_instr_q;
    assign instr_pc    = fifo_nonempty ? wpc_q[rd_ptr_q] : hold_pc_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
endmodule
